// File: rtl/fbdisp_pkg.sv
// -----------------------------------------------------------------------------
// fbdisp_pkg
// Shared definitions for the framebuffer display stage:
//   - default 640x480@60 VGA timing and derived totals / sync positions
//   - counter, zoom and framebuffer address widths, pipeline depth
//   - window_t: image size and centred offset for a given zoom
//   - ctl_t: per-pixel control bundle carried alongside the RAM read
//   - clamp_zoom / zoom_window helper functions
// -----------------------------------------------------------------------------
package fbdisp_pkg;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BP         = 48;
  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;

  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_FP         = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BP         = 33;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  localparam int CNT_W      = 10;
  localparam int ADDR_W     = 19;
  localparam int ZOOM_W     = 3;
  localparam int PIPE_DEPTH = 3;

  localparam logic [ZOOM_W-1:0] ZOOM_MAX = 3'd4;
  localparam logic [ZOOM_W-1:0] ZOOM_RST = 3'd2;

  typedef struct packed {
    logic [CNT_W-1:0] w;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] x0;
    logic [CNT_W-1:0] y0;
  } window_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic first;
    logic show;
    logic border;
  } ctl_t;

  // Idle control: syncs deasserted (high), everything else off.
  localparam ctl_t CTL_IDLE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [ZOOM_W-1:0] clamp_zoom(input logic [ZOOM_W-1:0] z);
    return (z > ZOOM_MAX) ? ZOOM_MAX : z;
  endfunction

  // Image is the active area divided by 2^(4-z): quarter size at z=2,
  // full screen at z=4. Offset centres it.
  function automatic window_t zoom_window(input logic [ZOOM_W-1:0] zc,
                                          input logic [CNT_W-1:0]  h_act,
                                          input logic [CNT_W-1:0]  v_act);
    window_t          win;
    logic [ZOOM_W-1:0] sh;
    sh     = ZOOM_MAX - zc;
    win.w  = h_act >> sh;
    win.h  = v_act >> sh;
    win.x0 = (h_act - win.w) >> 1;
    win.y0 = (v_act - win.h) >> 1;
    return win;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running VGA raster counters.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   h, v              current column / line (registered counters)
//   hsync, vsync      active-low syncs decoded from the counters
//   active            visible region flag
//   frame_first       high at h==0 && v==0
//   last_cycle        high at the final cycle of a frame
// -----------------------------------------------------------------------------
module vga_timing_gen
  import fbdisp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             frame_first,
  output logic             last_cycle
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= v_wrap ? '0 : v + CNT_W'(1);
    end else begin
      h <= h + CNT_W'(1);
    end
  end

  assign hsync       = !((h >= HS_START) && (h < HS_END));
  assign vsync       = !((v >= VS_START) && (v < VS_END));
  assign active      = (h < H_ACT) && (v < V_ACT);
  assign frame_first = (h == '0) && (v == '0);
  assign last_cycle  = h_wrap && v_wrap;

endmodule

// File: rtl/framebuffer_display.sv
// -----------------------------------------------------------------------------
// framebuffer_display
// Scans a VGA raster and shows the processed image from the output framebuffer
// centred on a black surround. Image size follows the zoom setting latched at
// the end of each frame; nothing is shown until the processor reports a
// completed frame after reset or after a zoom change.
// Optional feature macro: FBDISP_BORDER_EN -- draws a 1-pixel white frame
// around the image while an image is ready.
// Ports:
//   clk, rst_n                 pixel clock, async active-low reset
//   zoom_level[2:0]            processor zoom (values >4 treated as 4)
//   proc_done                  processor frame-complete pulse
//   fb_rd_addr[18:0]           framebuffer read address (registered)
//   fb_rd_data[7:0]            framebuffer data, one cycle after address
//   vga_hsync, vga_vsync       active-low syncs
//   vga_blank_n                high during visible pixels
//   vga_r, vga_g, vga_b        grayscale pixel
//   frame_start                pulse with output pixel (0,0)
// -----------------------------------------------------------------------------
module framebuffer_display
  import fbdisp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  zoom_level,
  input  logic        proc_done,
  output logic [18:0] fb_rd_addr,
  input  logic [7:0]  fb_rd_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0]  h;
  logic [CNT_W-1:0]  v;
  logic              hsync_p0;
  logic              vsync_p0;
  logic              active_p0;
  logic              first_p0;
  logic              last_p0;

  logic [ZOOM_W-1:0] zoom_q;
  logic [ZOOM_W-1:0] zoom_in;
  logic              image_ready;

  window_t           win;
  logic [CNT_W-1:0]  x_end;
  logic [CNT_W-1:0]  y_end;
  logic              in_win_p0;
  logic              border_p0;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_cur;

  ctl_t              ctl_p0;
  ctl_t              ctl_p1;
  ctl_t              ctl_p2;
  logic [7:0]        pix_p2;
  logic [7:0]        pix_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .h           (h),
    .v           (v),
    .hsync       (hsync_p0),
    .vsync       (vsync_p0),
    .active      (active_p0),
    .frame_first (first_p0),
    .last_cycle  (last_p0)
  );

  // ---- T0: counter cycle -- zoom latch, ready flag, window and pointer ----

  assign zoom_in = clamp_zoom(zoom_level);

  // A zoom change invalidates the stored image and overrides a coincident
  // proc_done; the new image size takes effect from the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zoom_q      <= ZOOM_RST;
      image_ready <= 1'b0;
    end else begin
      if (last_p0) begin
        zoom_q <= zoom_in;
      end
      if (last_p0 && (zoom_in != zoom_q)) begin
        image_ready <= 1'b0;
      end else if (proc_done) begin
        image_ready <= 1'b1;
      end
    end
  end

  assign win       = zoom_window(zoom_q, H_ACT_C, V_ACT_C);
  assign x_end     = win.x0 + win.w;
  assign y_end     = win.y0 + win.h;
  assign in_win_p0 = (h >= win.x0) && (h < x_end) && (v >= win.y0) && (v < y_end);

`ifdef FBDISP_BORDER_EN
  // One-pixel ring around the window. Compare against h+1 / v+1 so that a
  // window at x0=0 or y0=0 needs no negative offset; the active gate clips
  // the ring to the visible area.
  logic [CNT_W:0] h_inc;
  logic [CNT_W:0] v_inc;
  logic           ring;

  assign h_inc = {1'b0, h} + (CNT_W+1)'(1);
  assign v_inc = {1'b0, v} + (CNT_W+1)'(1);
  assign ring  = (h_inc >= {1'b0, win.x0}) && (h <= x_end) &&
                 (v_inc >= {1'b0, win.y0}) && (v <= y_end);
  assign border_p0 = ring && !in_win_p0 && active_p0 && image_ready;
`else
  assign border_p0 = 1'b0;
`endif

  // The pointer restarts at the top-left of each frame; at full-screen zoom
  // (0,0) is itself in the window, so the restart value is used directly.
  assign ptr_cur = first_p0 ? '0 : ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      fb_rd_addr <= '0;
    end else begin
      ptr <= in_win_p0 ? ptr_cur + ADDR_W'(1) : ptr_cur;
      if (in_win_p0) begin
        fb_rd_addr <= ptr_cur;
      end
    end
  end

  always_comb begin
    ctl_p0        = CTL_IDLE;
    ctl_p0.hsync  = hsync_p0;
    ctl_p0.vsync  = vsync_p0;
    ctl_p0.active = active_p0;
    ctl_p0.first  = first_p0;
    ctl_p0.show   = in_win_p0 && image_ready;
    ctl_p0.border = border_p0;
  end

  // ---- T1: address registered / T2: RAM data valid ----

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_p1 <= CTL_IDLE;
      ctl_p2 <= CTL_IDLE;
    end else begin
      ctl_p1 <= ctl_p0;
      ctl_p2 <= ctl_p1;
    end
  end

  always_comb begin
    pix_p2 = 8'h00;
    if (ctl_p2.show) begin
      pix_p2 = fb_rd_data;
    end else if (ctl_p2.border) begin
      pix_p2 = 8'hFF;
    end
  end

  // ---- T3: registered outputs ----

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      pix_q       <= 8'h00;
    end else begin
      vga_hsync   <= ctl_p2.hsync;
      vga_vsync   <= ctl_p2.vsync;
      vga_blank_n <= ctl_p2.active;
      frame_start <= ctl_p2.first;
      pix_q       <= pix_p2;
    end
  end

  assign vga_r = pix_q;
  assign vga_g = pix_q;
  assign vga_b = pix_q;

endmodule

// File: tb/tb_framebuffer_display.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_display
// Drives a reduced raster (64x48 visible, same window rules) so that many
// frames fit in a short run. A reference model computes, for every counter
// cycle, the expected syncs/blank/frame_start/pixel and read address directly
// from raster position, latched zoom and ready state, then compares them
// three cycles later against the DUT outputs. The framebuffer is modelled as a
// registered RAM whose content is addr[7:0]^0xA5.
// -----------------------------------------------------------------------------
module tb_framebuffer_display;

  localparam int HA = 64;
  localparam int HFP = 4;
  localparam int HS = 8;
  localparam int HBP = 4;
  localparam int VA = 48;
  localparam int VFP = 2;
  localparam int VS = 2;
  localparam int VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  localparam logic [27:0] RST_PAT = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  zoom_level;
  logic        proc_done;
  logic [18:0] fb_rd_addr;
  logic [7:0]  fb_rd_data;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;

  framebuffer_display #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .zoom_level  (zoom_level),
    .proc_done   (proc_done),
    .fb_rd_addr  (fb_rd_addr),
    .fb_rd_data  (fb_rd_data),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_blank_n (vga_blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int k;

  // reference model state
  int          m_zoom;
  bit          m_ready;
  int          m_addr;
  logic [18:0] prev_addr;
  logic [27:0] d1, d2, d3;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d h=%0d v=%0d: got %h, want %h", tag, k, k % HT, (k / HT) % VT, got, exp);
    end
  endtask

  function automatic logic [7:0] ram_rd(input logic [18:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // image size: full area scaled by 2^z/16 (z=2 quarter, z=4 full)
  function automatic int img_w(input int z);
    return (HA / 16) * (1 << z);
  endfunction

  function automatic int img_h(input int z);
    return (VA / 16) * (1 << z);
  endfunction

  task automatic check_rst(input string tag);
    check_vec({tag, "_video"},
              {4'h0, vga_hsync, vga_vsync, vga_blank_n, frame_start, vga_r, vga_g, vga_b},
              {4'h0, RST_PAT});
    check_vec({tag, "_addr"}, {13'h0, fb_rd_addr}, 32'h0);
  endtask

  task automatic model_reset();
    m_zoom    = 2;
    m_ready   = 1'b0;
    m_addr    = 0;
    prev_addr = '0;
    d1 = RST_PAT;
    d2 = RST_PAT;
    d3 = RST_PAT;
    k  = 0;
  endtask

  // One counter cycle: called at a falling edge, returns at the next one.
  task automatic step(input logic pd, input logic [2:0] zl);
    int          h, v, w, hh, x0, y0, idx;
    bit          inw, act, brd;
    logic [7:0]  pix;
    logic [2:0]  zc;
    logic [27:0] e;

    proc_done  = pd;
    zoom_level = zl;
    fb_rd_data = ram_rd(prev_addr);
    prev_addr  = fb_rd_addr;

    check_vec("video",
              {4'h0, vga_hsync, vga_vsync, vga_blank_n, frame_start, vga_r, vga_g, vga_b},
              {4'h0, d3});
    check_vec("rd_addr", {13'h0, fb_rd_addr}, m_addr);

    h   = k % HT;
    v   = (k / HT) % VT;
    w   = img_w(m_zoom);
    hh  = img_h(m_zoom);
    x0  = (HA - w) / 2;
    y0  = (VA - hh) / 2;
    act = (h < HA) && (v < VA);
    inw = (h >= x0) && (h < x0 + w) && (v >= y0) && (v < y0 + hh);
    brd = 1'b0;
`ifdef FBDISP_BORDER_EN
    brd = act && m_ready && !inw &&
          (h >= x0 - 1) && (h <= x0 + w) && (v >= y0 - 1) && (v <= y0 + hh);
`endif
    idx = (v - y0) * w + (h - x0);
    if (inw && m_ready) pix = ram_rd(19'(idx));
    else if (brd)       pix = 8'hFF;
    else                pix = 8'h00;
    e = {!((h >= HA + HFP) && (h < HA + HFP + HS)),
         !((v >= VA + VFP) && (v < VA + VFP + VS)),
         act, (h == 0) && (v == 0), pix, pix, pix};
    if (inw) m_addr = idx;

    if ((h == HT - 1) && (v == VT - 1)) begin
      zc = (zl > 3'd4) ? 3'd4 : zl;
      if (int'(zc) != m_zoom) m_ready = 1'b0;
      else if (pd)            m_ready = 1'b1;
      m_zoom = int'(zc);
    end else if (pd) begin
      m_ready = 1'b1;
    end

    d3 = d2;
    d2 = d1;
    d1 = e;
    k++;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] cur_zl;
    logic [2:0] new_zl;
    int         chg_line;
    int         run_len;

    rst_n      = 1'b0;
    zoom_level = 3'd2;
    proc_done  = 1'b0;
    fb_rd_data = 8'h00;
    k          = 0;
    cur_zl     = 3'd7;
    new_zl     = 3'd0;

    repeat (5) begin
      @(negedge clk);
      check_rst("reset");
    end
    rst_n = 1'b1;
    model_reset();

    // Directed frames: late proc_done (tearing), zoom 2->3 mid-frame,
    // zoom change coinciding with proc_done, clamp of 7 to full screen.
    for (int c = 0; c < 5 * FRAME; c++) begin
      int f, h, v;
      bit last;
      logic pd;
      logic [2:0] zl;
      f    = c / FRAME;
      h    = c % HT;
      v    = (c / HT) % VT;
      last = (h == HT - 1) && (v == VT - 1);
      pd   = 1'b0;
      zl   = 3'd2;
      case (f)
        0: begin zl = 3'd2; pd = (v == 22) && (h == 5); end
        1: begin zl = (v >= 10) ? 3'd3 : 3'd2; end
        2: begin zl = last ? 3'd7 : 3'd3; pd = last; end
        3: begin zl = 3'd7; pd = (v == VT - 3) && (h == 0); end
        default: begin zl = 3'd7; end
      endcase
      step(pd, zl);
    end

    // Randomized frames: zoom changes on even frames, proc_done late in
    // every frame plus sparse random pulses.
    for (int fr = 0; fr < 4; fr++) begin
      if (fr % 2 == 0) begin
        new_zl   = (fr == 0) ? 3'd0 : 3'($urandom_range(0, 7));
        chg_line = $urandom_range(1, VT - 3);
      end
      for (int c = 0; c < FRAME; c++) begin
        int h, v;
        logic pd;
        h = k % HT;
        v = (k / HT) % VT;
        if ((fr % 2 == 0) && (v == chg_line) && (h == 0)) cur_zl = new_zl;
        pd = ((v == VT - 2) && (h == 0)) || ($urandom_range(0, 1999) == 0);
        step(pd, cur_zl);
      end
    end

    // Part of a frame, then an asynchronous reset mid-frame.
    run_len = 1500 + $urandom_range(0, 1000);
    for (int c = 0; c < run_len; c++) begin
      step(($urandom_range(0, 299) == 0), cur_zl);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_rst("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_rst("reset_hold");
    end
    rst_n = 1'b1;
    model_reset();

    new_zl = 3'($urandom_range(0, 7));
    for (int c = 0; c < 2 * FRAME; c++) begin
      int f, h, v;
      logic pd;
      f  = c / FRAME;
      h  = c % HT;
      v  = (c / HT) % VT;
      pd = (f == 0) ? ((v == 5) && (h == 0)) : ((v == VT - 2) && (h == 0));
      step(pd, (f == 0) ? 3'd2 : new_zl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
